// File: rtl/cu_pkg.sv
// Shared encodings for the accumulator-machine controller and its datapath:
// FSM state codes, IR[7:5] opcodes and accumulator-source select codes.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_LOAD    = 4'd2,
        S_STORE   = 4'd3,
        S_ADD     = 4'd4,
        S_SUB     = 4'd5,
        S_IN_WAIT = 4'd6,
        S_IN_LOAD = 4'd7,
        S_IN_REL  = 4'd8,
        S_JZ      = 4'd9,
        S_JPOS    = 4'd10,
        S_HALT    = 4'd11
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_MEM = 2'b01;
    localparam logic [1:0] ASEL_IN  = 2'b10;

    function automatic state_t op_to_state(input logic [2:0] op);
        case (op)
            OP_LOAD:  return S_LOAD;
            OP_STORE: return S_STORE;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_IN:    return S_IN_WAIT;
            OP_JZ:    return S_JZ;
            OP_JPOS:  return S_JPOS;
            default:  return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Accumulator-machine controller: FETCH, DECODE, execute (3 cycles per instruction;
// IN adds an operator handshake). Outputs are Moore except PCload in JZ/JPOS.
module control_unit
    import cu_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [2:0] i_ir,
    input  logic       i_aeq0,
    input  logic       i_apos,
    input  logic       i_enter,
    output logic       o_irload,
    output logic       o_jmpmux,
    output logic       o_pcload,
    output logic       o_meminst,
    output logic       o_memwr,
    output logic       o_aload,
    output logic       o_sub,
    output logic [1:0] o_asel,
    output logic       o_halt,
    output logic [3:0] o_state
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE:  w_next = op_to_state(i_ir);
            S_IN_WAIT: w_next = i_enter ? S_IN_LOAD : S_IN_WAIT;
            S_IN_LOAD: w_next = S_IN_REL;
            // Hold here until the key is released so one press loads A once.
            S_IN_REL:  w_next = i_enter ? S_IN_REL : S_FETCH;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        o_irload  = 1'b0;
        o_jmpmux  = 1'b0;
        o_pcload  = 1'b0;
        o_meminst = 1'b0;
        o_memwr   = 1'b0;
        o_aload   = 1'b0;
        o_sub     = 1'b0;
        o_asel    = ASEL_ALU;
        o_halt    = 1'b0;
        if (i_reset_n) begin
            case (r_state)
                S_FETCH: begin
                    o_irload = 1'b1;
                    o_pcload = 1'b1;
                end
                S_DECODE: o_meminst = 1'b1;
                S_LOAD: begin
                    o_meminst = 1'b1;
                    o_asel    = ASEL_MEM;
                    o_aload   = 1'b1;
                end
                S_STORE: begin
                    o_meminst = 1'b1;
                    o_memwr   = 1'b1;
                end
                S_ADD: begin
                    o_meminst = 1'b1;
                    o_aload   = 1'b1;
                end
                S_SUB: begin
                    o_meminst = 1'b1;
                    o_sub     = 1'b1;
                    o_aload   = 1'b1;
                end
                S_IN_WAIT: o_asel = ASEL_IN;
                S_IN_LOAD: begin
                    o_asel  = ASEL_IN;
                    o_aload = 1'b1;
                end
                S_JZ: begin
                    o_jmpmux = 1'b1;
                    o_pcload = i_aeq0;
                end
                S_JPOS: begin
                    o_jmpmux = 1'b1;
                    o_pcload = i_apos;
                end
                S_HALT:  o_halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each driven cycle pushes the expected state and
// control vector, which is popped and compared once the outputs have settled.
module tb_control_unit;
    import cu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [2:0] ir;
    logic       aeq0;
    logic       apos;
    logic       enter;
    logic       irload, jmpmux, pcload, meminst, memwr, aload, sub, halt;
    logic [1:0] asel;
    logic [3:0] state;

    int checks;
    int failures;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [9:0] ctrl;
    } exp_t;

    exp_t sb[$];

    // Control vector order: irload jmpmux pcload meminst memwr aload sub asel[1:0] halt
    localparam logic [9:0] C_ZERO   = 10'b0_0_0_0_0_0_0_00_0;
    localparam logic [9:0] C_FETCH  = 10'b1_0_1_0_0_0_0_00_0;
    localparam logic [9:0] C_DECODE = 10'b0_0_0_1_0_0_0_00_0;
    localparam logic [9:0] C_LOAD   = 10'b0_0_0_1_0_1_0_01_0;
    localparam logic [9:0] C_STORE  = 10'b0_0_0_1_1_0_0_00_0;
    localparam logic [9:0] C_ADD    = 10'b0_0_0_1_0_1_0_00_0;
    localparam logic [9:0] C_SUB    = 10'b0_0_0_1_0_1_1_00_0;
    localparam logic [9:0] C_INWAIT = 10'b0_0_0_0_0_0_0_10_0;
    localparam logic [9:0] C_INLOAD = 10'b0_0_0_0_0_1_0_10_0;
    localparam logic [9:0] C_JMP_T  = 10'b0_1_1_0_0_0_0_00_0;
    localparam logic [9:0] C_JMP_N  = 10'b0_1_0_0_0_0_0_00_0;
    localparam logic [9:0] C_HALT   = 10'b0_0_0_0_0_0_0_00_1;

    control_unit dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_ir      (ir),
        .i_aeq0    (aeq0),
        .i_apos    (apos),
        .i_enter   (enter),
        .o_irload  (irload),
        .o_jmpmux  (jmpmux),
        .o_pcload  (pcload),
        .o_meminst (meminst),
        .o_memwr   (memwr),
        .o_aload   (aload),
        .o_sub     (sub),
        .o_asel    (asel),
        .o_halt    (halt),
        .o_state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl_now();
        return {irload, jmpmux, pcload, meminst, memwr, aload, sub, asel, halt};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then compare settled outputs.
    task automatic step(input string tag, input logic [2:0] t_ir, input logic t_en,
                        input logic t_a0, input logic t_ap,
                        input state_t t_st, input logic [9:0] t_ctrl);
        exp_t e;
        @(negedge clk);
        ir    = t_ir;
        enter = t_en;
        aeq0  = t_a0;
        apos  = t_ap;
        sb.push_back('{tag, 4'(t_st), t_ctrl});
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, "_state"}, 16'(state), 16'(e.st));
            check_eq({e.tag, "_ctrl"}, 16'(ctrl_now()), 16'(e.ctrl));
        end
    endtask

    // Straight-line instruction: FETCH, DECODE, one execute cycle.
    task automatic run_simple(input string tag, input logic [2:0] op, input logic a0,
                              input logic ap, input state_t ex_st, input logic [9:0] ex_ctrl);
        step({tag, "_fetch"},  op, 1'b0, a0, ap, S_FETCH, C_FETCH);
        step({tag, "_decode"}, op, 1'($urandom_range(0, 1)), a0, ap, S_DECODE, C_DECODE);
        step({tag, "_exec"},   op, 1'($urandom_range(0, 1)), a0, ap, ex_st, ex_ctrl);
    endtask

    task automatic reset_release();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ir       = OP_LOAD;
        aeq0     = 1'b0;
        apos     = 1'b0;
        enter    = 1'b0;

        #3;
        check_eq("reset_state", 16'(state), 16'(S_FETCH));
        check_eq("reset_ctrl", 16'(ctrl_now()), 16'(C_ZERO));
        @(posedge clk);
        #1;
        check_eq("reset_held_ctrl", 16'(ctrl_now()), 16'(C_ZERO));
        reset_release();

        run_simple("load",  OP_LOAD,  1'b1, 1'b1, S_LOAD,  C_LOAD);
        run_simple("store", OP_STORE, 1'b0, 1'b1, S_STORE, C_STORE);
        run_simple("add",   OP_ADD,   1'b1, 1'b0, S_ADD,   C_ADD);
        run_simple("sub",   OP_SUB,   1'b0, 1'b0, S_SUB,   C_SUB);
        run_simple("jz_t",  OP_JZ,    1'b1, 1'b0, S_JZ,    C_JMP_T);
        run_simple("jz_n",  OP_JZ,    1'b0, 1'b1, S_JZ,    C_JMP_N);
        run_simple("jpos_t", OP_JPOS, 1'b0, 1'b1, S_JPOS,  C_JMP_T);
        run_simple("jpos_n", OP_JPOS, 1'b1, 1'b0, S_JPOS,  C_JMP_N);

        // PCload follows the flag combinationally within the JZ cycle.
        step("jzc_fetch",  OP_JZ, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);
        step("jzc_decode", OP_JZ, 1'b0, 1'b0, 1'b0, S_DECODE, C_DECODE);
        step("jzc_exec",   OP_JZ, 1'b0, 1'b0, 1'b0, S_JZ, C_JMP_N);
        aeq0 = 1'b1;
        #1 check_eq("jz_comb_pcload", 16'(pcload), 16'd1);

        // IN: five cycles waiting, key held four cycles, one load.
        step("in_fetch",  OP_IN, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);
        step("in_decode", OP_IN, 1'b0, 1'b0, 1'b0, S_DECODE, C_DECODE);
        for (int i = 0; i < 4; i++)
            step("in_wait", OP_IN, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 S_IN_WAIT, C_INWAIT);
        step("in_wait_key", OP_IN, 1'b1, 1'b0, 1'b0, S_IN_WAIT, C_INWAIT);
        step("in_load",     OP_IN, 1'b1, 1'b0, 1'b0, S_IN_LOAD, C_INLOAD);
        step("in_rel_held", OP_IN, 1'b1, 1'b0, 1'b0, S_IN_REL, C_ZERO);
        step("in_rel_held", OP_IN, 1'b1, 1'b0, 1'b0, S_IN_REL, C_ZERO);
        step("in_rel_up",   OP_IN, 1'b0, 1'b0, 1'b0, S_IN_REL, C_ZERO);
        step("in_done",     OP_LOAD, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);

        // Key already down on entry to IN_WAIT.
        step("inq_decode", OP_IN, 1'b1, 1'b0, 1'b0, S_DECODE, C_DECODE);
        step("inq_wait",   OP_IN, 1'b1, 1'b0, 1'b0, S_IN_WAIT, C_INWAIT);
        step("inq_load",   OP_IN, 1'b1, 1'b0, 1'b0, S_IN_LOAD, C_INLOAD);
        step("inq_rel",    OP_IN, 1'b0, 1'b0, 1'b0, S_IN_REL, C_ZERO);
        step("inq_done",   OP_STORE, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);

        // Asynchronous reset mid-STORE.
        step("rs_decode", OP_STORE, 1'b0, 1'b0, 1'b0, S_DECODE, C_DECODE);
        step("rs_store",  OP_STORE, 1'b0, 1'b0, 1'b0, S_STORE, C_STORE);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rs_memwr", 16'(memwr), 16'd0);
        check_eq("rs_state", 16'(state), 16'(S_FETCH));
        reset_release();

        // Asynchronous reset mid-IN handshake.
        step("ri_fetch",  OP_IN, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);
        step("ri_decode", OP_IN, 1'b0, 1'b0, 1'b0, S_DECODE, C_DECODE);
        step("ri_wait",   OP_IN, 1'b1, 1'b0, 1'b0, S_IN_WAIT, C_INWAIT);
        step("ri_load",   OP_IN, 1'b1, 1'b0, 1'b0, S_IN_LOAD, C_INLOAD);
        #1 rst_n = 1'b0;
        #1;
        check_eq("ri_state", 16'(state), 16'(S_FETCH));
        check_eq("ri_ctrl", 16'(ctrl_now()), 16'(C_ZERO));
        reset_release();

        // HALT holds for 20 cycles regardless of inputs, then reset recovers.
        step("h_fetch",  OP_HALT, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);
        step("h_decode", OP_HALT, 1'b0, 1'b0, 1'b0, S_DECODE, C_DECODE);
        for (int i = 0; i < 20; i++)
            step("halt", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), S_HALT, C_HALT);
        #1 rst_n = 1'b0;
        #1 check_eq("h_reset_state", 16'(state), 16'(S_FETCH));
        reset_release();
        run_simple("post_halt", OP_ADD, 1'b0, 1'b0, S_ADD, C_ADD);
        step("post_halt_fetch", OP_LOAD, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);

        check_eq("sb_drained", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 IR  input  3  opcode from datapath IR[7:5]: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT.
REQ-004 Aeq0, Apos  input  1 each  accumulator flags from datapath.
REQ-005 Enter  input  1  operator key, level, synchronous to Clock.
REQ-006 IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub  output  1 each  datapath controls.
REQ-007 Asel  output  2  accumulator source: 00 ALU, 01 memory, 10 INPUT.
REQ-008 Halt  output  1  high while in HALT state.
REQ-009 State  output  4  current state encoding, for debug.

Function
REQ-010 States SHALL be FETCH, DECODE, LOAD, STORE, ADD, SUB, IN_WAIT, IN_LOAD, IN_REL, JZ, JPOS, HALT.
REQ-011 All outputs SHALL default to 0 in every state; only listed outputs assert.
REQ-012 FETCH: IRload=1, PCload=1, JMPmux=0; next DECODE.
REQ-013 DECODE: Meminst=1; next state selected by IR per REQ-003 (IN -> IN_WAIT).
REQ-014 LOAD: Meminst=1, Asel=01, Aload=1; next FETCH.
REQ-015 STORE: Meminst=1, MemWr=1; next FETCH.
REQ-016 ADD: Meminst=1, Asel=00, Sub=0, Aload=1; next FETCH.
REQ-017 SUB: Meminst=1, Asel=00, Sub=1, Aload=1; next FETCH.
REQ-018 IN_WAIT: Asel=10; stay while Enter=0; Enter=1 -> IN_LOAD.
REQ-019 IN_LOAD: Asel=10, Aload=1 for exactly one cycle; next IN_REL.
REQ-020 IN_REL: stay while Enter=1; Enter=0 -> FETCH; one key press SHALL load A exactly once.
REQ-021 JZ: JMPmux=1, PCload=Aeq0 (combinational from flag); next FETCH.
REQ-022 JPOS: JMPmux=1, PCload=Apos (combinational from flag); next FETCH.
REQ-023 HALT: Halt=1, all other controls 0; remain until Reset.
REQ-024 Apart from REQ-021/022, outputs SHALL be Moore (decoded from state only).
REQ-025 Instruction latency: 3 cycles for LOAD/STORE/ADD/SUB/JZ/JPOS; IN = 2 + wait + 1 + release cycles.
REQ-026 Enter already high on entry to IN_WAIT SHALL proceed to IN_LOAD next cycle.
REQ-027 Enter, Aeq0, Apos SHALL be ignored outside the states naming them.
REQ-028 Unused state encodings SHALL transition to FETCH with all outputs 0.

Reset
REQ-029 Reset=0 SHALL force FETCH immediately (asynchronous), including mid-instruction and mid-IN handshake.
REQ-030 During reset all control outputs and Halt SHALL be 0; State shows FETCH encoding.
REQ-031 First rising Clock after Reset deasserts SHALL execute FETCH.

Structure
REQ-032 Shared package cu_pkg SHALL hold state encodings, opcode constants and Asel codes; the datapath SHALL use the same opcode/Asel constants.
REQ-033 Single module: state register plus next-state/output logic; no sub-module.

Verification
REQ-034 Reset low mid-STORE -> MemWr drops to 0 without Clock edge; State=FETCH.
REQ-035 IR=000 after FETCH -> cycle sequence FETCH(IRload=1,PCload=1), DECODE(Meminst=1), LOAD(Asel=01,Aload=1), FETCH.
REQ-036 IR=100, Enter held 0 for 5 cycles then 1 for 4 cycles -> IN_WAIT 5 cycles, Aload=1 exactly one cycle with Asel=10, IN_REL until Enter=0, then FETCH.
REQ-037 IR=101 with Aeq0=1 -> JMPmux=1, PCload=1 in JZ; repeat with Aeq0=0 -> PCload=0.
REQ-038 IR=110 with Apos=1 then Apos=0 -> PCload 1 then 0; IR=011 -> Sub=1, Aload=1, Asel=00.
REQ-039 IR=111 -> Halt=1 held 20 cycles with all controls 0; Reset pulse -> FETCH.
